modaddsub_vec: RTL and testbench
================================

// Module: modaddsub_vec
// PURPOSE
//  NL-lane pipelined modular adder/subtractor with per-lane op select, valid/ready flow control and a
//  registered modulus. Modulus q = {qH, {(LOGQ-LOGQH-1){1'b0}}, 1'b1} (NTT-friendly form). Sits between
//  the NTT butterfly datapath and the coefficient buffers as the vector successor of the scalar modadd.
// PARAMETERS
//  NL      4   number of lanes
//  LOGQ    64  coefficient / modulus width
//  LOGQH   47  width of qH; LOGQ-LOGQH >= 2
//  TAGW    8   sideband tag width, carried unchanged with each vector
//  FF_IN   1   input register stage (0/1)
//  FF_ADD  1   register after raw sum/difference stage (0/1)
//  FF_OUT  1   output register stage (0/1); LAT = FF_IN+FF_ADD+FF_OUT, LAT >= 1 enforced by elaboration check
// PORTS
//  clk        in   1         clock
//  rst        in   1         synchronous, active-high reset
//  q_ld       in   1         load qH register from q_qH
//  q_qH       in   LOGQH     new modulus high part
//  q_err      out  1         1-cycle pulse: q_ld rejected (pipeline not idle)
//  idle       out  1         no valid vector in any stage
//  in_valid   in   1         input vector valid
//  in_ready   out  1         block accepts input this cycle
//  in_op      in   NL        per-lane op: 0 = add, 1 = sub (A-B)
//  in_a       in   NL*LOGQ   operand A, lane i at [i*LOGQ +: LOGQ]
//  in_b       in   NL*LOGQ   operand B, same packing
//  in_tag     in   TAGW      sideband tag
//  out_valid  out  1         output vector valid
//  out_ready  in   1         downstream accepts output
//  out_c      out  NL*LOGQ   result, same packing
//  out_tag    out  TAGW      tag of the vector on out_c
// BEHAVIOUR
//  - Reset: all stage valids 0, out_valid 0, out_c 0, out_tag 0, qH reg 0, q_err 0, idle 1. rst mid-stream
//    drops every in-flight vector; out_valid is 0 the cycle after rst is sampled.
//  - Arithmetic per lane (operands precondition A,B < q; not checked): add: R=A+B (LOGQ+1 b), Rq=R-q;
//    C = Rq[LOGQ] ? R : Rq. sub: R=A-B (LOGQ+1 b); C = R[LOGQ] ? R+q : R. C truncated to LOGQ bits.
//  - Pipeline: global enable en = !out_valid | out_ready; in_ready = en. Transfer on in_valid & in_ready.
//    All stages (data, op, tag, valid) advance only when en. Bubbles are carried (no collapse).
//  - Latency: vector accepted at edge k appears with out_valid=1 after edge k+LAT-1... i.e. LAT edges
//    after acceptance when en stays 1; throughput 1 vector/cycle. Order preserved, no loss/dup under stall.
//  - out_c/out_tag hold stable while out_valid & !out_ready.
//  - Modulus: q_ld sampled when idle=1 and no in_valid&in_ready this cycle -> qH reg updated at that edge,
//    used by vectors accepted afterwards. q_ld otherwise ignored, qH unchanged, q_err=1 next cycle only.
//    q_ld and input transfer in the same cycle -> q_ld rejected (q_err), vector uses old q.
//  - idle = no stage valid (including output register); combinational from stage valids.
// STRUCTURE
//  - modop_pkg: MODOP_ADD=1'b0 / MODOP_SUB=1'b1 constants, function q_full(qH) building q from qH.
//  - Sub-module modaddsub_lane: one lane, FF_ADD-split arithmetic, no control; instantiated NL times.
//    Top holds valid/tag pipeline, enable, qH register, q_err, idle.
// TESTING (NL=4, LOGQ=64, LOGQH=47, all FF=1, qH=47'h400008C00000 -> q=64'h8000118000000001)
//  1 add, A=64'h010000000000000A B=64'h1000000000000005 all lanes -> C=64'h110000000000000F, 3 edges later.
//  2 add wrap A=q-1=64'h8000118000000000 B=2 -> C=1; sub A=5 B=7 -> C=64'h8000117FFFFFFFFF; sub A=B -> 0;
//    mixed in_op=4'b1010 in one vector -> each lane matches its own op.
//  3 stream 8 vectors tag 0..7, out_ready=0 for 3 cycles mid-stream -> in_ready=0 same cycles, outputs
//    tags 0..7 in order, each exactly once, out_c stable during stall.
//  4 q_ld while a vector in flight -> q_err pulse 1 cycle, results use old q; q_ld when idle with
//    qH=47'h000000000001 (q=64'h0000000000020001) -> next add A=64'h20000 B=2 gives C=1.
//  5 rst asserted with 3 vectors in flight -> next cycle out_valid=0, idle=1, out_c=0, qH=0; post-reset
//    stream behaves as scenario 3.
//  6 random: 10k vectors, random in_valid/out_ready, random ops, A,B<q -> all match scoreboard model.

Source files
------------

// File: rtl/modop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modop_pkg
// Description : Op-select constants and modulus builder shared by the
//               modular add/sub datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package modop_pkg;

    localparam logic MODOP_ADD = 1'b0;
    localparam logic MODOP_SUB = 1'b1;

    // Wide enough for any supported LOGQ; callers truncate to their width.
    localparam int c_QMAX_W = 128;

    // q = {qH, zeros, 1}: qH sits above (LOGQ-LOGQH) low bits, LSB forced to 1.
    function automatic logic [c_QMAX_W-1:0] q_full(input logic [c_QMAX_W-1:0] i_qh,
                                                   input int i_logq,
                                                   input int i_logqh);
        return (i_qh << (i_logq - i_logqh)) | c_QMAX_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/modaddsub_lane.sv
`default_nettype none
// ============================================================================
// Module      : modaddsub_lane
// Description : One lane of the modular adder/subtractor, optional registers
//               at input, after the raw sum/difference, and at the output.
// Revision    : 1.0 - initial release
// ============================================================================
module modaddsub_lane
    import modop_pkg::*;
#(
    parameter int LOGQ   = 64,
    parameter int FF_IN  = 1,
    parameter int FF_ADD = 1,
    parameter int FF_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_op,
    input  logic [LOGQ-1:0] i_a,
    input  logic [LOGQ-1:0] i_b,
    input  logic [LOGQ-1:0] i_q,
    output logic [LOGQ-1:0] o_c
);

    logic [LOGQ-1:0] w_a, w_b;
    logic            w_op;
    logic [LOGQ:0]   w_raw;
    logic [LOGQ:0]   w_r;
    logic            w_rop;
    logic [LOGQ:0]   w_rq;
    logic [LOGQ-1:0] w_c;

    generate
        if (FF_IN != 0) begin : g_in_reg
            logic [LOGQ-1:0] r_a, r_b;
            logic            r_op;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a  <= '0;
                    r_b  <= '0;
                    r_op <= MODOP_ADD;
                end else if (i_en) begin
                    r_a  <= i_a;
                    r_b  <= i_b;
                    r_op <= i_op;
                end
            end
            assign w_a  = r_a;
            assign w_b  = r_b;
            assign w_op = r_op;
        end else begin : g_in_comb
            assign w_a  = i_a;
            assign w_b  = i_b;
            assign w_op = i_op;
        end
    endgenerate

    // One extra bit holds the carry (add) or the borrow sign (sub).
    assign w_raw = (w_op == MODOP_SUB) ? ({1'b0, w_a} - {1'b0, w_b})
                                       : ({1'b0, w_a} + {1'b0, w_b});

    generate
        if (FF_ADD != 0) begin : g_add_reg
            logic [LOGQ:0] r_r;
            logic          r_rop;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_r   <= '0;
                    r_rop <= MODOP_ADD;
                end else if (i_en) begin
                    r_r   <= w_raw;
                    r_rop <= w_op;
                end
            end
            assign w_r   = r_r;
            assign w_rop = r_rop;
        end else begin : g_add_comb
            assign w_r   = w_raw;
            assign w_rop = w_op;
        end
    endgenerate

    assign w_rq = w_r - {1'b0, i_q};
    assign w_c  = (w_rop == MODOP_SUB)
                ? (w_r[LOGQ] ? (w_r[LOGQ-1:0] + i_q) : w_r[LOGQ-1:0])
                : (w_rq[LOGQ] ? w_r[LOGQ-1:0] : w_rq[LOGQ-1:0]);

    generate
        if (FF_OUT != 0) begin : g_out_reg
            logic [LOGQ-1:0] r_c;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_c <= '0;
                end else if (i_en) begin
                    r_c <= w_c;
                end
            end
            assign o_c = r_c;
        end else begin : g_out_comb
            assign o_c = w_c;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/modaddsub_vec.sv
`default_nettype none
// ============================================================================
// Module      : modaddsub_vec
// Description : NL-lane pipelined modular adder/subtractor with valid/ready
//               flow control, tag sideband and a loadable modulus.
// Revision    : 1.0 - initial release
// ============================================================================
module modaddsub_vec
    import modop_pkg::*;
#(
    parameter int NL     = 4,
    parameter int LOGQ   = 64,
    parameter int LOGQH  = 47,
    parameter int TAGW   = 8,
    parameter int FF_IN  = 1,
    parameter int FF_ADD = 1,
    parameter int FF_OUT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_ld,
    input  logic [LOGQH-1:0]   q_qH,
    output logic               q_err,
    output logic               idle,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NL-1:0]      in_op,
    input  logic [NL*LOGQ-1:0] in_a,
    input  logic [NL*LOGQ-1:0] in_b,
    input  logic [TAGW-1:0]    in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NL*LOGQ-1:0] out_c,
    output logic [TAGW-1:0]    out_tag
);

    localparam int LAT = FF_IN + FF_ADD + FF_OUT;

    generate
        if (LAT < 1 || (LOGQ - LOGQH) < 2) begin : g_param_check
            $error("modaddsub_vec: need LAT >= 1 and LOGQ-LOGQH >= 2");
        end
    endgenerate

    logic                w_en;
    logic                w_xfer;
    logic [LAT-1:0]      r_vld;
    logic [TAGW-1:0]     r_tag [LAT];
    logic [LOGQH-1:0]    r_qh;
    logic                r_qerr;
    logic [LOGQ-1:0]     w_q;

    assign w_en      = !r_vld[LAT-1] || out_ready;
    assign w_xfer    = in_valid && w_en;
    assign in_ready  = w_en;
    assign out_valid = r_vld[LAT-1];
    assign out_tag   = r_tag[LAT-1];
    assign idle      = ~|r_vld;
    assign q_err     = r_qerr;

    // Valid and tag travel alongside the lane data, one slot per register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else if (w_en) begin
            for (int i = LAT - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
            r_vld[0] <= in_valid;
            r_tag[0] <= in_tag;
        end
    end

    // Modulus only changes with an empty pipe, so in-flight lanes need no copy of q.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_qh   <= '0;
            r_qerr <= 1'b0;
        end else begin
            r_qerr <= 1'b0;
            if (q_ld) begin
                if (idle && !w_xfer) begin
                    r_qh <= q_qH;
                end else begin
                    r_qerr <= 1'b1;
                end
            end
        end
    end

    assign w_q = LOGQ'(q_full(c_QMAX_W'(r_qh), LOGQ, LOGQH));

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            modaddsub_lane #(
                .LOGQ   (LOGQ),
                .FF_IN  (FF_IN),
                .FF_ADD (FF_ADD),
                .FF_OUT (FF_OUT)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .i_en (w_en),
                .i_op (in_op[gi]),
                .i_a  (in_a[gi*LOGQ +: LOGQ]),
                .i_b  (in_b[gi*LOGQ +: LOGQ]),
                .i_q  (w_q),
                .o_c  (out_c[gi*LOGQ +: LOGQ])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_modaddsub_vec.sv
`default_nettype none
// ============================================================================
// Module      : tb_modaddsub_vec
// Description : Self-checking bench for modaddsub_vec with a transaction-level
//               reference model (per-vector age counters and a result queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modaddsub_vec;

    localparam int NL    = 4;
    localparam int LOGQ  = 64;
    localparam int LOGQH = 47;
    localparam int TAGW  = 8;
    localparam int LAT   = 3;
    localparam int VW    = NL * LOGQ;
    localparam logic [LOGQH-1:0] QH0 = 47'h400008C00000;

    logic               clk;
    logic               rst;
    logic               q_ld;
    logic [LOGQH-1:0]   q_qH;
    logic               q_err;
    logic               idle;
    logic               in_valid;
    logic               in_ready;
    logic [NL-1:0]      in_op;
    logic [VW-1:0]      in_a;
    logic [VW-1:0]      in_b;
    logic [TAGW-1:0]    in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [VW-1:0]      out_c;
    logic [TAGW-1:0]    out_tag;

    modaddsub_vec #(
        .NL(NL), .LOGQ(LOGQ), .LOGQH(LOGQH), .TAGW(TAGW),
        .FF_IN(1), .FF_ADD(1), .FF_OUT(1)
    ) dut (
        .clk(clk), .rst(rst), .q_ld(q_ld), .q_qH(q_qH), .q_err(q_err), .idle(idle),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state
    logic [LOGQH-1:0] m_qh   = '0;
    logic             m_qerr = 1'b0;
    logic [VW-1:0]    exp_c[$];
    logic [TAGW-1:0]  exp_tag[$];
    int               exp_age[$];
    logic [TAGW-1:0]  popped[$];
    bit               last_acc;

    function automatic logic [LOGQ-1:0] q_of(input logic [LOGQH-1:0] qh);
        return {qh, {(LOGQ-LOGQH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [LOGQ-1:0] mod_ref(input bit sub, input logic [LOGQ-1:0] a,
                                                input logic [LOGQ-1:0] b,
                                                input logic [LOGQ-1:0] q);
        logic [LOGQ:0] s;
        if (!sub) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, q}) s = s - {1'b0, q};
        end else if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, q} - {1'b0, b};
        end
        return s[LOGQ-1:0];
    endfunction

    function automatic logic [VW-1:0] vec_ref(input logic [NL-1:0] op, input logic [VW-1:0] a,
                                              input logic [VW-1:0] b, input logic [LOGQ-1:0] q);
        logic [VW-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++)
            r[l*LOGQ +: LOGQ] = mod_ref(op[l], a[l*LOGQ +: LOGQ], b[l*LOGQ +: LOGQ], q);
        return r;
    endfunction

    function automatic logic [LOGQ-1:0] rnd_below(input logic [LOGQ-1:0] q);
        logic [LOGQ-1:0] v;
        v = {$urandom(), $urandom()};
        return v % q;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock cycle: compare DUT against the model, clock, then advance the model.
    task automatic tick();
        bit m_ov, m_en;
        #1;
        m_ov = (exp_age.size() > 0) && (exp_age[0] >= LAT);
        m_en = !m_ov || out_ready;
        chk("in_ready", in_ready, m_en);
        chk("out_valid", out_valid, m_ov);
        chk("idle", idle, exp_age.size() == 0);
        chk("q_err", q_err, m_qerr);
        if (m_ov) begin
            chk("out_c", out_c, exp_c[0]);
            chk("out_tag", out_tag, exp_tag[0]);
        end
        last_acc = in_valid && m_en && !rst;
        @(posedge clk);
        if (rst) begin
            exp_c.delete(); exp_tag.delete(); exp_age.delete();
            m_qh = '0; m_qerr = 1'b0;
        end else begin
            m_qerr = 1'b0;
            if (q_ld) begin
                if (exp_age.size() == 0 && !(in_valid && m_en)) m_qh = q_qH;
                else m_qerr = 1'b1;
            end
            if (m_ov && out_ready) begin
                popped.push_back(out_tag);
                void'(exp_c.pop_front()); void'(exp_tag.pop_front()); void'(exp_age.pop_front());
            end
            if (m_en) foreach (exp_age[i]) exp_age[i] = exp_age[i] + 1;
            if (in_valid && m_en) begin
                exp_c.push_back(vec_ref(in_op, in_a, in_b, q_of(m_qh)));
                exp_tag.push_back(in_tag);
                exp_age.push_back(1);
            end
        end
        #1;
    endtask

    task automatic set_all(input logic [NL-1:0] op, input logic [LOGQ-1:0] a,
                           input logic [LOGQ-1:0] b, input logic [TAGW-1:0] tag);
        in_op = op; in_a = {NL{a}}; in_b = {NL{b}}; in_tag = tag;
    endtask

    task automatic set_rand(input logic [TAGW-1:0] tag);
        for (int l = 0; l < NL; l++) begin
            in_a[l*LOGQ +: LOGQ] = rnd_below(q_of(m_qh));
            in_b[l*LOGQ +: LOGQ] = rnd_below(q_of(m_qh));
        end
        in_op = NL'($urandom()); in_tag = tag;
    endtask

    task automatic send_wait(output logic [VW-1:0] c, output int lat);
        out_ready = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        c = out_c;
        tick();
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; q_ld = 1'b0;
        for (int k = 0; k < 50 && exp_age.size() > 0; k++) tick();
        chk("drain_idle", idle, 1'b1);
    endtask

    task automatic load_q(input logic [LOGQH-1:0] qh);
        q_ld = 1'b1; q_qH = qh; in_valid = 1'b0;
        tick();
        q_ld = 1'b0;
    endtask

    task automatic stream8();
        logic [VW-1:0] stall_c;
        int sent;
        sent = 0;
        popped.delete();
        for (int cyc = 0; cyc < 60 && (sent < 8 || exp_age.size() > 0); cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 7);
            in_valid  = (sent < 8);
            set_rand(TAGW'(sent));
            if (cyc == 5) stall_c = out_c;
            if (cyc == 6) chk("stall_hold_c", out_c, stall_c);
            tick();
            if (last_acc) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", popped.size(), 8);
        for (int i = 0; i < 8 && i < popped.size(); i++) chk("stream_tag_order", popped[i], i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] c;
        int lat;
        int sent;

        rst = 1'b1; q_ld = 1'b0; q_qH = '0; in_valid = 1'b0; in_op = '0;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        tick();
        chk("reset_out_c", out_c, '0);
        chk("reset_out_tag", out_tag, '0);
        rst = 1'b0;
        load_q(QH0);

        // Basic add and latency
        set_all(4'b0000, 64'h010000000000000A, 64'h1000000000000005, 8'h11);
        send_wait(c, lat);
        chk("add_basic", c, {NL{64'h110000000000000F}});
        chk("add_latency", lat, LAT);

        // Wrap and subtraction corner cases
        set_all(4'b0000, 64'h8000118000000000, 64'd2, 8'h21);
        send_wait(c, lat);
        chk("add_wrap", c, {NL{64'h1}});
        set_all(4'b1111, 64'd5, 64'd7, 8'h22);
        send_wait(c, lat);
        chk("sub_neg", c, {NL{64'h8000117FFFFFFFFF}});
        set_all(4'b1111, 64'h123456789, 64'h123456789, 8'h23);
        send_wait(c, lat);
        chk("sub_equal", c, '0);
        set_all(4'b1010, 64'd5, 64'd7, 8'h24);
        send_wait(c, lat);
        chk("mixed_ops", c, {64'h8000117FFFFFFFFF, 64'd12, 64'h8000117FFFFFFFFF, 64'd12});

        // Streaming with a downstream stall
        stream8();
        drain();

        // Modulus load rejected while busy, then accepted when idle
        set_rand(8'h40); in_valid = 1'b1; tick();
        in_valid = 1'b0; q_ld = 1'b1; q_qH = 47'h1; tick();
        q_ld = 1'b0;
        chk("q_err_busy", q_err, 1'b1);
        tick();
        chk("q_err_pulse_end", q_err, 1'b0);
        drain();
        set_rand(8'h41); in_valid = 1'b1; q_ld = 1'b1; q_qH = 47'h1; tick();
        in_valid = 1'b0; q_ld = 1'b0;
        chk("q_err_same_cycle", q_err, 1'b1);
        drain();
        load_q(47'h1);
        chk("q_ld_idle_noerr", q_err, 1'b0);
        set_all(4'b0000, 64'h20000, 64'd2, 8'h42);
        send_wait(c, lat);
        chk("add_small_q", c, {NL{64'h1}});

        // Reset with vectors in flight
        load_q(QH0);
        for (int i = 0; i < 3; i++) begin
            set_rand(TAGW'(8'h50 + i)); in_valid = 1'b1; tick();
        end
        in_valid = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_out_c", out_c, '0);
        load_q(QH0);
        stream8();
        drain();

        // Random traffic, occasional modulus reloads
        sent = 0;
        for (int cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 8);
            q_ld      = ($urandom_range(0, 199) == 0);
            q_qH      = LOGQH'({$urandom(), $urandom()});
            set_rand(TAGW'(sent));
            tick();
            if (last_acc) sent++;
        end
        chk("random_sent", sent, 10000);
        drain();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
